// File: rtl/sdram_controller_emulator.sv
// sdram_controller_emulator: BRAM-backed cycle-level stand-in for the SDRAM controller user interface
module sdram_controller_emulator #(
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int INIT_CYCLES    = 16,
    parameter int READ_LATENCY   = 4
) (
    input  logic        I_sdrc_clk,
    input  logic        I_sdrc_rst_n,
    input  logic        I_sdrc_cmd_en,
    input  logic [2:0]  I_sdrc_cmd,
    input  logic        I_sdrc_precharge_ctrl,
    input  logic        I_sdram_power_down,
    input  logic        I_sdram_selfrefresh,
    input  logic [20:0] I_sdrc_addr,
    input  logic [3:0]  I_sdrc_dqm,
    input  logic [31:0] I_sdrc_data,
    input  logic [7:0]  I_sdrc_data_len,
    output logic [31:0] O_sdrc_data,
    output logic        O_sdrc_init_done,
    output logic        O_sdrc_cmd_ack,
    output logic        O_err
);
    typedef enum logic [2:0] {INIT, IDLE, WR_BURST, RD_WAIT, RD_BURST} state_t;
    localparam logic [15:0] IC_LAST = 16'(INIT_CYCLES - 1);
    localparam logic [7:0]  RL_WAIT = 8'(READ_LATENCY - 2);
    state_t state, state_n;
    logic [31:0] mem [2**MEM_ADDR_WIDTH];
    logic [10:0] open_row [4];
    logic [3:0]  valid;
    logic [15:0] icnt;
    logic [1:0]  b_bank;
    logic [10:0] b_row;
    logic [7:0]  b_col, cnt, wcnt;
    logic        b_ap;
    logic [1:0]  bank;
    logic [10:0] row;
    logic [7:0]  col;
    logic accept, is_act, is_pre, is_wr, is_rd, start_wr, start_rd;
    logic wr_en, rd_step, burst_end, bad;
    logic [MEM_ADDR_WIDTH-1:0] wr_idx, rd_idx;
    function automatic logic [MEM_ADDR_WIDTH-1:0] idx(input logic [1:0] b, input logic [10:0] r,
                                                      input logic [7:0] c);
        logic [20:0] full;
        full = {b, r, c};
        return full[MEM_ADDR_WIDTH-1:0];
    endfunction
    assign bank      = I_sdrc_addr[20:19];
    assign row       = I_sdrc_addr[18:8];
    assign col       = I_sdrc_addr[7:0];
    assign accept    = (state == IDLE) && I_sdrc_cmd_en;
    assign is_act    = I_sdrc_cmd == 3'b011;
    assign is_pre    = I_sdrc_cmd == 3'b010;
    assign is_wr     = I_sdrc_cmd == 3'b100;
    assign is_rd     = I_sdrc_cmd == 3'b101;
    assign start_wr  = accept && is_wr && valid[bank];
    assign start_rd  = accept && is_rd && valid[bank];
    assign wr_en     = I_sdrc_rst_n && (start_wr || state == WR_BURST);
    assign wr_idx    = (state == WR_BURST) ? idx(b_bank, b_row, b_col) : idx(bank, open_row[bank], col);
    assign rd_idx    = idx(b_bank, b_row, b_col);
    assign rd_step   = (state == RD_WAIT && wcnt == 8'd0) || (state == RD_BURST && cnt != 8'd0);
    assign burst_end = (state == WR_BURST && cnt == 8'd1) || (state == RD_BURST && cnt == 8'd0);
    assign bad       = (I_sdrc_cmd_en && state != IDLE) || I_sdram_power_down || I_sdram_selfrefresh ||
                       (accept && (is_wr || is_rd) && !valid[bank]);
    assign O_sdrc_init_done = state != INIT;
    always_ff @(posedge I_sdrc_clk) begin
        if (!I_sdrc_rst_n) state <= INIT;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            INIT:     state_n = (icnt == IC_LAST) ? IDLE : INIT;
            IDLE:     state_n = start_rd ? RD_WAIT : (start_wr && I_sdrc_data_len != 8'd0) ? WR_BURST : IDLE;
            WR_BURST: state_n = (cnt == 8'd1) ? IDLE : WR_BURST;
            RD_WAIT:  state_n = (wcnt == 8'd0) ? RD_BURST : RD_WAIT;
            RD_BURST: state_n = (cnt == 8'd0) ? IDLE : RD_BURST;
            default:  state_n = INIT;
        endcase
    end
    always_ff @(posedge I_sdrc_clk) begin
        if (!I_sdrc_rst_n) begin
            O_sdrc_data    <= 32'd0;
            O_sdrc_cmd_ack <= 1'b0;
            O_err          <= 1'b0;
            valid          <= 4'd0;
            icnt           <= 16'd0;
        end else begin
            O_sdrc_cmd_ack <= accept;
            if (bad) O_err <= 1'b1;
            if (state == INIT) icnt <= icnt + 16'd1;
            if (accept && is_act) begin
                open_row[bank] <= row;
                valid[bank]    <= 1'b1;
            end
            if (accept && is_pre) valid[bank] <= 1'b0;
            if (start_wr || start_rd) begin
                b_bank <= bank;
                b_row  <= open_row[bank];
                b_col  <= start_wr ? col + 8'd1 : col;
                cnt    <= I_sdrc_data_len;
                wcnt   <= RL_WAIT;
                b_ap   <= I_sdrc_precharge_ctrl;
            end
            if (start_wr && I_sdrc_data_len == 8'd0 && I_sdrc_precharge_ctrl) valid[bank] <= 1'b0;
            if (state == WR_BURST) begin
                b_col <= b_col + 8'd1;
                cnt   <= cnt - 8'd1;
            end
            if (state == RD_WAIT) wcnt <= wcnt - 8'd1;
            if (rd_step) begin
                O_sdrc_data <= mem[rd_idx];
                b_col       <= b_col + 8'd1;
            end
            if (state == RD_BURST && cnt != 8'd0) cnt <= cnt - 8'd1;
            if (burst_end && b_ap) valid[b_bank] <= 1'b0;
        end
    end
    always_ff @(posedge I_sdrc_clk) begin
        if (wr_en)
            for (int i = 0; i < 4; i++)
                if (!I_sdrc_dqm[i]) mem[wr_idx][8*i +: 8] <= I_sdrc_data[8*i +: 8];
    end
endmodule

// File: tb/tb_sdram_controller_emulator.sv
// tb_sdram_controller_emulator: directed table-driven bench for the SDRAM controller emulator
module tb_sdram_controller_emulator;
    localparam int RL = 4;
    localparam int IC = 16;
    localparam logic [2:0] NOP = 3'b000, REF = 3'b001, PRE = 3'b010, ACT = 3'b011, WR = 3'b100, RD = 3'b101;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_en = 1'b0;
    logic [2:0]  cmd = 3'd0;
    logic        pc = 1'b0;
    logic        pdn = 1'b0;
    logic        sref = 1'b0;
    logic [20:0] addr = 21'd0;
    logic [3:0]  dqm = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic [7:0]  len = 8'd0;
    logic [31:0] rdata;
    logic        init_done, ack, err;
    int errors = 0;
    int checks = 0;
    logic [31:0] model [4096];
    logic [10:0] brow [4];
    typedef struct {
        logic [2:0]  cmd;
        logic [20:0] addr;
        logic [7:0]  len;
        logic        pc;
        logic [31:0] base;
        int          dq_k;
        logic [3:0]  dq_m;
        logic [31:0] exp_first;
        logic        exp_err;
    } vec_t;
    vec_t tbl [18];

    sdram_controller_emulator #(.MEM_ADDR_WIDTH(12), .INIT_CYCLES(IC), .READ_LATENCY(RL)) dut (
        .I_sdrc_clk(clk), .I_sdrc_rst_n(rst_n), .I_sdrc_cmd_en(cmd_en), .I_sdrc_cmd(cmd),
        .I_sdrc_precharge_ctrl(pc), .I_sdram_power_down(pdn), .I_sdram_selfrefresh(sref),
        .I_sdrc_addr(addr), .I_sdrc_dqm(dqm), .I_sdrc_data(wdata), .I_sdrc_data_len(len),
        .O_sdrc_data(rdata), .O_sdrc_init_done(init_done), .O_sdrc_cmd_ack(ack), .O_err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int bidx(input logic [20:0] a, input logic [10:0] r, input int k);
        int c;
        c = (int'(a[7:0]) + k) % 256;
        return ((int'(a[20:19]) << 19) + (int'(r) << 8) + c) % 4096;
    endfunction

    task automatic mwrite(input logic [20:0] a, input int k, input logic [31:0] d, input logic [3:0] m);
        int ix;
        ix = bidx(a, brow[a[20:19]], k);
        for (int i = 0; i < 4; i++)
            if (!m[i]) model[ix][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (!init_done && n < 100) begin
            tick();
            n++;
        end
        chk("init_cycles", n, IC);
    endtask

    function automatic vec_t mk(input logic [2:0] c, input logic [20:0] a, input logic [7:0] l, input logic p,
                                input logic [31:0] b, input int k, input logic [3:0] m, input logic [31:0] f);
        vec_t v;
        v.cmd = c; v.addr = a; v.len = l; v.pc = p; v.base = b;
        v.dq_k = k; v.dq_m = m; v.exp_first = f; v.exp_err = 1'b0;
        return v;
    endfunction

    task automatic run(input vec_t v);
        int n;
        int ix;
        n = int'(v.len);
        cmd_en = 1'b1; cmd = v.cmd; addr = v.addr; len = v.len; pc = v.pc;
        wdata = v.base; dqm = (v.dq_k == 0) ? v.dq_m : 4'h0;
        if (v.cmd == WR) mwrite(v.addr, 0, wdata, dqm);
        tick();
        cmd_en = 1'b0;
        chk("cmd_ack", {31'd0, ack}, 32'd1);
        if (v.cmd == ACT) brow[v.addr[20:19]] = v.addr[18:8];
        if (v.cmd == WR)
            for (int k = 1; k <= n; k++) begin
                wdata = v.base + 32'(k);
                dqm = (v.dq_k == k) ? v.dq_m : 4'h0;
                mwrite(v.addr, k, wdata, dqm);
                tick();
            end
        dqm = 4'h0;
        if (v.cmd == RD) begin
            repeat (RL - 1) tick();
            chk("rd_first", rdata, v.exp_first);
            for (int k = 0; k <= n; k++) begin
                ix = bidx(v.addr, brow[v.addr[20:19]], k);
                chk("rd_word", rdata, model[ix]);
                tick();
            end
            chk("rd_hold", rdata, model[ix]);
        end
        chk("err", {31'd0, err}, {31'd0, v.exp_err});
    endtask

    initial begin
        tbl[0]  = mk(ACT, 21'h000000, 8'd0, 1'b0, 32'h0, 0, 4'h0, 32'h0);
        tbl[1]  = mk(WR,  21'h000000, 8'd7, 1'b0, 32'h1234_5678, 0, 4'h0, 32'h0);
        tbl[2]  = mk(RD,  21'h000000, 8'd7, 1'b0, 32'h0, 0, 4'h0, 32'h1234_5678);
        tbl[3]  = mk(REF, 21'h000000, 8'd0, 1'b0, 32'h0, 0, 4'h0, 32'h0);
        tbl[4]  = mk(ACT, 21'h000100, 8'd0, 1'b0, 32'h0, 0, 4'h0, 32'h0);
        tbl[5]  = mk(WR,  21'h000100, 8'd7, 1'b0, 32'h1010_2020, 0, 4'h0, 32'h0);
        tbl[6]  = mk(RD,  21'h000104, 8'd3, 1'b0, 32'h0, 0, 4'h0, 32'h1010_2024);
        tbl[7]  = mk(WR,  21'h0001FE, 8'd3, 1'b0, 32'h5555_0000, 0, 4'h0, 32'h0);
        tbl[8]  = mk(WR,  21'h0001FE, 8'd3, 1'b0, 32'hAAAA_BB00, 1, 4'b0011, 32'h0);
        tbl[9]  = mk(RD,  21'h0001FE, 8'd3, 1'b0, 32'h0, 0, 4'h0, 32'hAAAA_BB00);
        tbl[10] = mk(RD,  21'h0001FF, 8'd0, 1'b0, 32'h0, 0, 4'h0, 32'hAAAA_0001);
        tbl[11] = mk(RD,  21'h000100, 8'd1, 1'b0, 32'h0, 0, 4'h0, 32'hAAAA_BB02);
        tbl[12] = mk(ACT, 21'h000000, 8'd0, 1'b0, 32'h0, 0, 4'h0, 32'h0);
        tbl[13] = mk(RD,  21'h000000, 8'd7, 1'b0, 32'h0, 0, 4'h0, 32'h1234_5678);
        tbl[14] = mk(ACT, 21'h100500, 8'd0, 1'b0, 32'h0, 0, 4'h0, 32'h0);
        tbl[15] = mk(WR,  21'h100500, 8'd0, 1'b1, 32'hDEAD_BEEF, 0, 4'h0, 32'h0);
        tbl[16] = mk(ACT, 21'h100500, 8'd0, 1'b0, 32'h0, 0, 4'h0, 32'h0);
        tbl[17] = mk(RD,  21'h100500, 8'd0, 1'b1, 32'h0, 0, 4'h0, 32'hDEAD_BEEF);

        tick();
        tick();
        chk("rst_data", rdata, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        wait_init();
        chk("init_err", {31'd0, err}, 32'd0);
        chk("init_data", rdata, 32'd0);

        for (int i = 0; i < 18; i++) run(tbl[i]);

        // READ to bank 2, closed by the auto-precharge above: acked, flagged, output untouched
        cmd_en = 1'b1; cmd = RD; addr = 21'h100500; len = 8'd0; pc = 1'b0;
        tick();
        cmd_en = 1'b0;
        chk("norow_ack", {31'd0, ack}, 32'd1);
        chk("norow_err", {31'd0, err}, 32'd1);
        repeat (RL) tick();
        chk("norow_data", rdata, 32'hDEAD_BEEF);

        tbl[0] = mk(ACT, 21'h000100, 8'd0, 1'b0, 32'h0, 0, 4'h0, 32'h0);
        tbl[0].exp_err = 1'b1;
        run(tbl[0]);

        // reset in the middle of a read burst
        cmd_en = 1'b1; cmd = RD; addr = 21'h000104; len = 8'd3;
        tick();
        cmd_en = 1'b0;
        repeat (RL - 1) tick();
        chk("mid_rd_w0", rdata, 32'h1010_2024);
        tick();
        chk("mid_rd_w1", rdata, 32'h1010_2025);
        rst_n = 1'b0;
        tick();
        chk("rst2_data", rdata, 32'd0);
        chk("rst2_init_done", {31'd0, init_done}, 32'd0);
        chk("rst2_err", {31'd0, err}, 32'd0);
        chk("rst2_ack", {31'd0, ack}, 32'd0);
        rst_n = 1'b1;
        wait_init();

        tbl[0].exp_err = 1'b0;
        run(tbl[0]);

        // stray command during a write burst
        cmd_en = 1'b1; cmd = WR; addr = 21'h000110; len = 8'd3; wdata = 32'h7777_0000;
        mwrite(addr, 0, wdata, 4'h0);
        tick();
        chk("wb_ack", {31'd0, ack}, 32'd1);
        cmd = RD; wdata = 32'h7777_0001;
        mwrite(addr, 1, wdata, 4'h0);
        tick();
        cmd_en = 1'b0;
        chk("stray_ack", {31'd0, ack}, 32'd0);
        chk("stray_err", {31'd0, err}, 32'd1);
        for (int k = 2; k <= 3; k++) begin
            wdata = 32'h7777_0000 + 32'(k);
            mwrite(addr, k, wdata, 4'h0);
            tick();
        end

        tbl[1] = mk(RD, 21'h000110, 8'd3, 1'b0, 32'h0, 0, 4'h0, 32'h7777_0000);
        tbl[1].exp_err = 1'b1;
        run(tbl[1]);
        tbl[2] = mk(RD, 21'h000104, 8'd0, 1'b0, 32'h0, 0, 4'h0, 32'h1010_2024);
        tbl[2].exp_err = 1'b1;
        run(tbl[2]);
        tbl[3] = mk(RD, 21'h000000, 8'd0, 1'b0, 32'h0, 0, 4'h0, 32'hAAAA_BB02);
        tbl[3].exp_err = 1'b1;
        run(tbl[3]);

        rst_n = 1'b0;
        tick();
        chk("final_err_clear", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
